// File: rtl/flex_counter_chain.sv
// Cascade of flexible counters with run-time rollovers, a stage-0 step, parallel load and
// wrap / one-shot end-of-sequence handling. All outputs are registered.
module flex_counter_chain #(
    parameter int unsigned NUM_CNT_BITS = 10,
    parameter int unsigned NUM_STAGES   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 load,
    input  logic                                 count_enable,
    input  logic                                 mode,
    input  logic [NUM_CNT_BITS-1:0]              step,
    input  logic [NUM_STAGES*NUM_CNT_BITS-1:0]   rollover_val,
    input  logic [NUM_STAGES*NUM_CNT_BITS-1:0]   load_val,
    output logic [NUM_STAGES*NUM_CNT_BITS-1:0]   count_out,
    output logic [NUM_STAGES-1:0]                wrap_pulse,
    output logic                                 done
);

    localparam int unsigned W = NUM_CNT_BITS;

    logic [NUM_STAGES*W-1:0] count_q, count_d;
    logic [NUM_STAGES-1:0]   wrap_q, wrap_d;
    logic                    done_q, done_d;
    // Set when done came from a one-shot end, so it persists rather than pulsing.
    logic                    hold_q, hold_d;

    always_comb begin : next_state
        logic [NUM_STAGES*W-1:0] adv_count;
        logic [NUM_STAGES-1:0]   adv_wrap;
        logic                    carry;
        logic                    term;
        logic [W-1:0]            stp;
        logic [W:0]              sum;

        count_d   = count_q;
        wrap_d    = '0;
        done_d    = done_q;
        hold_d    = hold_q;
        adv_count = count_q;
        adv_wrap  = '0;
        carry     = count_enable & ~done_q;

        // Ripple the carry through all stages; the final carry marks the full-chain end.
        for (int k = 0; k < NUM_STAGES; k++) begin
            stp  = (k == 0) ? step : W'(1);
            sum  = {1'b0, count_q[k*W +: W]} + {1'b0, stp};
            term = (sum > {1'b0, rollover_val[k*W +: W]});
            if (carry) begin
                if (term) begin
                    adv_count[k*W +: W] = '0;
                    adv_wrap[k]         = 1'b1;
                end else begin
                    adv_count[k*W +: W] = sum[W-1:0];
                end
            end
            carry = carry & term;
        end

        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
            hold_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
            hold_d  = 1'b0;
        end else if (carry && mode) begin
            done_d = 1'b1;
            hold_d = 1'b1;
        end else begin
            count_d = adv_count;
            wrap_d  = adv_wrap;
            done_d  = carry | hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign count_out  = count_q;
    assign wrap_pulse = wrap_q;
    assign done       = done_q;

endmodule

// File: doc/flex_counter_chain.md
# flex_counter_chain

Parametrised cascade of flexible counters for multi-dimensional address and timing generation, such as pixel column → row → frame. Each stage has its own run-time rollover value. Stage 0 advances by a run-time step. The chain supports parallel load, and can either wrap continuously or stop at the end of the sequence (one-shot). It replaces hand-wired chains of single flex counters in the image pipeline's address generators.

## Interface
Parameters:
- NUM_CNT_BITS, 10, width of every stage counter (≥2)
- NUM_STAGES, 2, number of cascaded stages (≥1); stage 0 is least significant

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  zero all stages, clear done/pulses
- load  input  1  parallel load from load_val
- count_enable  input  1  advance request for stage 0
- mode  input  1  0 = wrap continuously, 1 = one-shot (stop at end)
- step  input  NUM_CNT_BITS  stage 0 increment per enable
- rollover_val  input  NUM_STAGES*NUM_CNT_BITS  per-stage max value; field k = bits [k*W +: W]
- load_val  input  NUM_STAGES*NUM_CNT_BITS  per-stage load value, same packing
- count_out  output  NUM_STAGES*NUM_CNT_BITS  registered stage counts, same packing
- wrap_pulse  output  NUM_STAGES  registered; bit k high for one cycle after stage k wrapped to 0
- done  output  1  registered; end-of-sequence indicator

## Operation
- Reset is synchronous and active-high: rst sampled high at a rising clk edge sets all of count_out, wrap_pulse and done to 0.
- Per-cycle priority: rst > clear > load > count_enable.
  - clear: all counts 0, wrap_pulse 0, done 0.
  - load: count k = load_val field k (not clamped), wrap_pulse 0, done 0.
- Stage step sizes: stage 0 uses step; stages k>0 use 1.
- Terminal condition for stage k: count_k + step_k > rollover_k.
  - Evaluate in NUM_CNT_BITS+1 bits; no overflow wrap of the sum.
  - For k>0 this reduces to count_k ≥ rollover_k.
- Carry: carry_0 = count_enable & ~done; carry_{k+1} = carry_k & terminal_k.
- Stage k update when carry_k = 1:
  - terminal: count_k becomes 0 and wrap_pulse[k] is set for the next cycle;
  - not terminal: count_k becomes count_k + step_k.
  - When carry_k = 0, count_k holds.
- Full-chain end: carry_{NUM_STAGES-1} & terminal_{NUM_STAGES-1}.
  - mode=0: all stages wrap to 0, wrap_pulse all 1, done high for exactly one cycle.
  - mode=1: all counts hold their current values, wrap_pulse 0, done set and held.
- While done=1, count_enable is ignored in either mode. done is cleared only by rst, clear or load.
- wrap_pulse and the mode=0 done pulse are 0 in every cycle not immediately following a qualifying event.
- Boundary cases:
  - rollover_k = 0: stage k is always terminal and stays 0; every carry into it wraps.
  - step = 0: stage 0 is terminal only if count_0 > rollover_0. Otherwise the chain holds with no pulses.
  - Loaded value above rollover_k: stage is terminal; the next carry into it wraps it to 0.
  - Non-multiple step: stage 0 wraps to exactly 0, and the remainder is discarded.
  - rollover_val, step and mode are sampled every cycle. A change takes effect on the next evaluation, with no resynchronisation.
  - clear or load in the same cycle as count_enable: the enable is lost.

## Timing
- Every output is registered. There is no combinational path from input to output.
- Latency is one cycle: an input event sampled at edge N is visible on count_out/wrap_pulse/done after edge N.
- The mode=0 done pulse is coincident with count_out = all zeros.
- In mode=1, done rises in the same cycle that the final count would have wrapped. count_out shows the terminal values.
- Throughput: one advance per cycle with count_enable held high.
- The carry chain is combinational across NUM_STAGES stages within a single cycle. Implementers must size NUM_STAGES ≤ 4 at 100 MHz.

## Test plan
All scenarios use NUM_CNT_BITS=4 and NUM_STAGES=2.
- Reset/clear: drive rst during counting → count_out=0x00, wrap_pulse=00, done=0 on the next cycle. Repeat with clear.
- Wrap mode: rollover={2,3} (stage1, stage0), step=1, mode=0, enable held.
  - Sequence (s1,s0): (0,1)(0,2)(0,3)(1,0)…(2,3)(0,0).
  - wrap_pulse[0] after each 3→0.
  - At the 12th enable: wrap_pulse=11 and done=1 for one cycle.
- One-shot: same setup with mode=1.
  - After 11 enables count=(2,3).
  - 12th enable → count stays (2,3), done=1.
  - A further 5 enables do not change it.
  - load of {1,1} → count=(1,1), done=0.
- Step/remainder: rollover0=9, step=4 → s0 sequence 0,4,8,0. s1 increments on the third enable.
- Boundaries:
  - rollover0=0 → s1 increments on every enable.
  - load s0=12 with rollover0=5 → next enable gives s0=0, wrap_pulse[0]=1.
  - step=0 → no change and no pulses.
- Simultaneous events: load with count_enable → load_val only. clear with load → 0. rst with clear/load/enable → 0.
